uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter B, default 8, meaning data byte width in bits.
REQ-002 The block SHALL have parameter GAP, default 16, meaning idle clocks inserted between consecutive bytes (0 = none).
REQ-003 The block SHALL have parameter TMO, default 65535, meaning max clocks waiting for tx_done_tick before abort.
REQ-004 The block SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port enable  input  1  high = drain FIFO; low = stop after current byte.
REQ-007 The block SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-008 The block SHALL have port fifo_r_data  input  B  FIFO head word, valid whenever fifo_empty=0 (fall-through).
REQ-009 The block SHALL have port fifo_rd  output  1  one-cycle pop strobe to FIFO.
REQ-010 The block SHALL have port tx_start  output  1  one-cycle start strobe to UART transmitter.
REQ-011 The block SHALL have port tx_din  output  B  byte presented to transmitter, held stable from tx_start until tx_done_tick.
REQ-012 The block SHALL have port tx_done_tick  input  1  one-cycle pulse from transmitter at end of stop bit.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 The block SHALL have port byte_cnt  output  16  count of bytes completed since reset.
REQ-015 The block SHALL have port tmo_err  output  1  sticky flag, transmitter failed to finish a byte.

Function
REQ-016 The block SHALL implement states IDLE, START, WAIT, GAP.
REQ-017 IDLE: when enable=1 and fifo_empty=0, fifo_rd SHALL be high combinationally that cycle, tx_din SHALL latch fifo_r_data on that edge, next state START; otherwise stay IDLE, fifo_rd=0.
REQ-018 fifo_rd SHALL never be high outside IDLE and never high while fifo_empty=1.
REQ-019 START: tx_start SHALL be high (decoded from state) for exactly one cycle, next state WAIT; timeout counter cleared to 0.
REQ-020 WAIT: on tx_done_tick=1, byte_cnt SHALL increment by 1 (wrap 0xFFFF->0x0000), next state GAP if GAP>0 else IDLE.
REQ-021 WAIT: each cycle without tx_done_tick the timeout counter SHALL increment; on reaching TMO, tmo_err SHALL set to 1, byte_cnt SHALL not change, next state IDLE.
REQ-022 tx_done_tick SHALL be ignored in IDLE, START and GAP.
REQ-023 GAP: state SHALL persist exactly GAP cycles, then IDLE.
REQ-024 Latency: enable=1 and fifo_empty=0 sampled at edge N -> fifo_rd high during cycle N, tx_start high during cycle N+1.
REQ-025 Byte period SHALL be: pop cycle + START + WAIT cycles up to and incl. done tick + GAP cycles; back-to-back pops SHALL be separated by at least GAP+3 cycles.
REQ-026 enable deasserted in START, WAIT or GAP: current byte and gap SHALL complete normally; no new pop.
REQ-027 tx_din SHALL change only on a pop edge.
REQ-028 tmo_err SHALL clear only on reset.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, tx_din=0, byte_cnt=0, tmo_err=0, timeout and gap counters 0; outputs fifo_rd=0, tx_start=0, busy=0.
REQ-030 Reset mid-byte SHALL abandon the byte without pop or count; after release the next eligible IDLE cycle pops normally.

Verification
REQ-031 FIFO holds 0x55, enable=1 -> fifo_rd one cycle, tx_start next cycle with tx_din=0x55, done tick after 10 cycles -> byte_cnt=1, busy low after 16 GAP cycles.
REQ-032 FIFO holds 0x11,0x22,0x33, GAP=16 -> three pops in order, tx_din 0x11/0x22/0x33, pops spaced >= 19 cycles, byte_cnt=3, fifo_empty=1 at end.
REQ-033 enable dropped during WAIT of byte 0xA0 with 0xA1 queued -> 0xA0 completes, byte_cnt+1, no pop of 0xA1 until enable=1.
REQ-034 TMO=100, no tx_done_tick -> tmo_err=1 after 100 WAIT cycles, state IDLE, byte_cnt unchanged, next byte popped if enable=1.
REQ-035 reset pulsed low during WAIT -> all outputs zero immediately, byte_cnt=0, tmo_err=0; FIFO entry not popped again by block.
REQ-036 byte_cnt preset path via 65536 completions -> wraps to 0x0000 without flag.

Source files
------------

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Drains a fall-through FIFO into a UART transmitter one byte at
//               a time. Pops the head word, strobes tx_start, waits for the
//               transmitter's done tick (with timeout), then holds a fixed
//               idle gap before the next byte. Counts completed bytes and
//               keeps a sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int B   = 8,
  parameter int GAP = 16,
  parameter int TMO = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         fifo_empty,
  input  logic [B-1:0] fifo_r_data,
  output logic         fifo_rd,
  output logic         tx_start,
  output logic [B-1:0] tx_din,
  input  logic         tx_done_tick,
  output logic         busy,
  output logic [15:0]  byte_cnt,
  output logic         tmo_err
);

  // Timeout counter only needs to reach TMO-1: the cycle that would make it
  // TMO is the abort cycle itself. Same reasoning for the gap counter.
  localparam int c_TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int c_GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'((TMO > 0) ? TMO - 1 : 0);
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_START = 2'd1;
  localparam logic [1:0] c_S_WAIT  = 2'd2;
  localparam logic [1:0] c_S_GAP   = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_TW-1:0] r_tmo_cnt;
  logic [c_GW-1:0] r_gap_cnt;
  logic [B-1:0]    r_tx_din;
  logic [15:0]     r_byte_cnt;
  logic            r_tmo_err;
  logic            w_pop;
  logic            w_tmo_hit;
  logic            w_gap_last;

  // Pop is gated by reset so the FIFO is never strobed while held in reset.
  assign w_pop      = (r_state == c_S_IDLE) & enable & ~fifo_empty & reset;
  assign w_tmo_hit  = (r_tmo_cnt == c_TMO_LAST);
  assign w_gap_last = (r_gap_cnt == c_GAP_LAST);

  assign tx_din   = r_tx_din;
  assign byte_cnt = r_byte_cnt;
  assign tmo_err  = r_tmo_err;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a done tick wins over a timeout landing on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_pop) w_state_nxt = c_S_START;
      end
      c_S_START: begin
        w_state_nxt = c_S_WAIT;
      end
      c_S_WAIT: begin
        if (tx_done_tick) begin
          w_state_nxt = (GAP > 0) ? c_S_GAP : c_S_IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = c_S_IDLE;
        end
      end
      c_S_GAP: begin
        if (w_gap_last) w_state_nxt = c_S_IDLE;
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  // Output decode from state (fifo_rd is the only input-dependent output).
  always_comb begin
    fifo_rd  = 1'b0;
    tx_start = 1'b0;
    busy     = 1'b0;
    case (r_state)
      c_S_IDLE:  fifo_rd = w_pop;
      c_S_START: begin
        tx_start = 1'b1;
        busy     = 1'b1;
      end
      c_S_WAIT:  busy = 1'b1;
      c_S_GAP:   busy = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // Datapath: byte latch, timeout/gap counters, completion count, sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_din   <= '0;
      r_tmo_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_byte_cnt <= 16'd0;
      r_tmo_err  <= 1'b0;
    end else begin
      if (w_pop) r_tx_din <= fifo_r_data;
      case (r_state)
        c_S_START: begin
          r_tmo_cnt <= '0;
        end
        c_S_WAIT: begin
          if (tx_done_tick) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
            r_gap_cnt  <= '0;
          end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        c_S_GAP: begin
          if (!w_gap_last) r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Self-checking bench for uart_tx_sched. A queue models the FIFO,
//               a behavioural transmitter answers tx_start after a chosen
//               delay (or never), and a timeline model predicts every output
//               from pop time, done time, GAP and TMO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int B   = 8;
  localparam int GAP = 16;
  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [B-1:0] fifo_r_data = '0;
  logic         fifo_rd;
  logic         tx_start;
  logic [B-1:0] tx_din;
  logic         tx_done_tick = 1'b0;
  logic         busy;
  logic [15:0]  byte_cnt;
  logic         tmo_err;

  uart_tx_sched #(.B(B), .GAP(GAP), .TMO(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_r_data  (fifo_r_data),
    .fifo_rd      (fifo_rd),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .byte_cnt     (byte_cnt),
    .tmo_err      (tmo_err)
  );

  always #5 clk = ~clk;

  // Environment / stimulus controls
  logic [B-1:0] q[$];
  bit  rst_drv  = 1'b0;
  bit  en_drv   = 1'b0;
  bit  spur_en  = 1'b0;
  bit  tmo_next = 1'b0;
  int  fixed_d  = 0;

  // Timeline model: cycle numbers of the current byte's events
  int           t         = 0;
  int           m_start   = -100;
  int           m_done    = -100;
  int           m_end     = -100;
  int           m_idle_at = 0;
  logic [15:0]  m_cnt     = 16'd0;
  logic         m_err     = 1'b0;
  logic [B-1:0] m_din     = '0;
  int           last_pop  = -1;
  int           n_pops    = 0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic int pick_delay();
    int r;
    if (fixed_d > 0) return fixed_d;
    r = int'($urandom_range(0, 15));
    if (r == 0) return TMO;
    if (r == 1) return TMO - 1;
    return int'($urandom_range(1, 25));
  endfunction

  // One clock cycle: drive inputs at the falling edge, check, advance model.
  task automatic step();
    int  t_end;
    bit  exp_rd;
    int  d;
    @(negedge clk);
    reset = rst_drv;
    if (!rst_drv) begin
      m_cnt = 16'd0; m_err = 1'b0; m_din = '0;
      m_start = -100; m_done = -100; m_end = -100; m_idle_at = 0;
      last_pop = -1;
    end
    t_end = (m_done >= 0) ? m_done : m_end;
    if (t == m_done)
      tx_done_tick = 1'b1;
    else if (spur_en && !(t > m_start && t <= t_end) && $urandom_range(0, 7) == 0)
      tx_done_tick = 1'b1;
    else
      tx_done_tick = 1'b0;
    fifo_empty  = (q.size() == 0);
    fifo_r_data = (q.size() != 0) ? q[0] : B'($urandom);
    enable      = en_drv;
    #1;
    exp_rd = rst_drv && (t >= m_idle_at) && en_drv && (q.size() != 0);
    chk("fifo_rd",  fifo_rd,  exp_rd);
    chk("tx_start", tx_start, (t == m_start));
    chk("busy",     busy,     (t >= m_start) && (t < m_idle_at));
    chk("tx_din",   tx_din,   m_din);
    chk("byte_cnt", byte_cnt, m_cnt);
    chk("tmo_err",  tmo_err,  m_err);
    if (rst_drv) begin
      if (exp_rd) begin
        m_din   = q[0];
        m_start = t + 1;
        m_end   = m_start + TMO;
        if (tmo_next) begin
          m_done    = -100;
          m_idle_at = m_end + 1;
          tmo_next  = 1'b0;
        end else begin
          d         = pick_delay();
          m_done    = m_start + d;
          m_idle_at = m_done + GAP + 1;
        end
      end
      if (t == m_done) m_cnt = m_cnt + 16'd1;
      if (m_done < 0 && t == m_end) m_err = 1'b1;
    end
    if (fifo_rd === 1'b1 && q.size() != 0) begin
      if (last_pop >= 0) chk("pop_spacing", (t - last_pop) >= GAP + 3, 1);
      last_pop = t;
      void'(q.pop_front());
      n_pops++;
    end
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_pops(input int target, input int budget);
    int i;
    i = 0;
    while (n_pops < target && i < budget) begin
      step();
      i++;
    end
    chk("wait_pop", n_pops >= target, 1);
  endtask

  initial begin
    int p0;
    // Reset state
    rst_drv = 1'b0; en_drv = 1'b1;
    q.push_back(8'h99);
    run(3);
    q.delete();
    rst_drv = 1'b1;
    run(2);

    // Single byte 0x55, done tick 10 cycles after start
    fixed_d = 10;
    q.push_back(8'h55);
    run(40);
    chk("single_cnt", byte_cnt, 16'd1);

    // Three queued bytes drained in order with gap spacing
    p0 = n_pops;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    fixed_d = 0;
    run(3 * (GAP + 30));
    chk("three_pops", n_pops - p0, 3);
    chk("fifo_drained", q.size() == 0, 1);

    // Enable dropped during WAIT: current byte completes, next not popped
    fixed_d = 15;
    q.push_back(8'hA0); q.push_back(8'hA1);
    run_until_pops(n_pops + 1, 100);
    run(4);
    en_drv = 1'b0;
    p0 = n_pops;
    run(80);
    chk("no_pop_disabled", n_pops, p0);
    en_drv = 1'b1;
    run(60);

    // Timeout: transmitter never answers, next byte still goes out
    fixed_d = 8;
    tmo_next = 1'b1;
    q.push_back(8'h77); q.push_back(8'h78);
    run(TMO + GAP + 50);
    chk("tmo_sticky", tmo_err, 1'b1);

    // Reset pulsed during WAIT
    fixed_d = 30;
    q.push_back(8'hC0); q.push_back(8'hC1);
    run_until_pops(n_pops + 1, 100);
    run(5);
    rst_drv = 1'b0;
    run(2);
    rst_drv = 1'b1;
    run(70);

    // Randomized traffic with spurious done ticks, timeouts and resets
    spur_en = 1'b1;
    fixed_d = 0;
    for (int i = 0; i < 3000; i++) begin
      if (q.size() < 8 && $urandom_range(0, 5) == 0) q.push_back(B'($urandom));
      en_drv = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 399) == 0) tmo_next = 1'b1;
      rst_drv = ($urandom_range(0, 1499) != 0);
      step();
    end
    rst_drv = 1'b1;
    en_drv  = 1'b1;
    spur_en = 1'b0;
    run(TMO + GAP + 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
